// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flow controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned PERF_W     = 32;

  // x0 is hard-wired, so a write to it never creates a hazard
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Control polarities as seen by the pipeline registers and the PC
  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic FLUSH_ENABLE = 1'b1;
  localparam logic JUMP_ENABLE  = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_MC_WAIT = 2'd1,
    CTRL_FLUSH   = 2'd2
  } ctrl_state_e;

  // Per-stage control bundle driven to the pipeline
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic pc_jump_ena;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use hazard detector (shared with the forwarding unit).
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_r_ena_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_r_ena_i,
  input  logic                  ex_mem_r_ena_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_w_addr_i,
  output logic                  lu_c
);

  logic rs1_hit;
  logic rs2_hit;

  // A load in EX whose destination is read by the instruction in ID
  always_comb begin
    rs1_hit = id_rs1_r_ena_i && (id_rs1_addr_i == ex_reg_w_addr_i);
    rs2_hit = id_rs2_r_ena_i && (id_rs2_addr_i == ex_reg_w_addr_i);
    lu_c    = ex_mem_r_ena_i && (ex_reg_w_addr_i != ZERO_REG) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flow controller: holds, flushes, PC redirect, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W             = 6,
  parameter int unsigned JUMP_FLUSH_CYCLES = 2
) (
  input  logic                  clk_100MHz,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_r_ena_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_r_ena_i,
  input  logic                  ex_mem_r_ena_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_w_addr_i,
  input  logic                  ex_jump_ena_i,
  input  logic [XLEN-1:0]       ex_jump_addr_i,
  input  logic                  ex_mc_start_i,
  input  logic [CNT_W-1:0]      ex_mc_cycles_i,
  input  logic                  bus_hold_i,
  output logic                  pc_hold_o,
  output logic                  if_id_hold_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_hold_o,
  output logic                  id_ex_flush_o,
  output logic                  pc_jump_ena_o,
  output logic [XLEN-1:0]       pc_jump_addr_o,
  output logic [STATE_W-1:0]    state_o,
  output logic [PERF_W-1:0]     stall_cnt_o,
  output logic [PERF_W-1:0]     flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] JUMP_LEFT = CNT_W'(JUMP_FLUSH_CYCLES - 1);

  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  pipe_ctrl_t        ctrl_c;
  pipe_ctrl_t        ctrl_gated_c;
  logic [XLEN-1:0]   jump_addr_c;
  logic              lu_c;

  pipe_ctrl_hazard u_hazard (
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs1_r_ena_i  (id_rs1_r_ena_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs2_r_ena_i  (id_rs2_r_ena_i),
    .ex_mem_r_ena_i  (ex_mem_r_ena_i),
    .ex_reg_w_addr_i (ex_reg_w_addr_i),
    .lu_c            (lu_c)
  );

  // State, down-counter and performance counters
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= CTRL_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_q + PERF_W'(ctrl_gated_c.pc_hold);
      flush_cnt_q <= flush_cnt_q + PERF_W'(ctrl_gated_c.pc_jump_ena);
    end
  end

  // Next state and zero-latency controls; a register never sees hold and flush together
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_c      = '0;
    jump_addr_c = '0;
    case (state_q)
      CTRL_RUN: begin
        if (ex_jump_ena_i) begin
          ctrl_c.pc_jump_ena = JUMP_ENABLE;
          ctrl_c.if_id_flush = FLUSH_ENABLE;
          ctrl_c.id_ex_flush = FLUSH_ENABLE;
          jump_addr_c        = ex_jump_addr_i;
          if (JUMP_FLUSH_CYCLES > 1) begin
            state_d = CTRL_FLUSH;
            cnt_d   = JUMP_LEFT;
          end
        end else if (bus_hold_i) begin
          ctrl_c.pc_hold    = HOLD_ENABLE;
          ctrl_c.if_id_hold = HOLD_ENABLE;
          ctrl_c.id_ex_hold = HOLD_ENABLE;
        end else if (ex_mc_start_i && (ex_mc_cycles_i != '0)) begin
          ctrl_c.pc_hold    = HOLD_ENABLE;
          ctrl_c.if_id_hold = HOLD_ENABLE;
          ctrl_c.id_ex_hold = HOLD_ENABLE;
          if (ex_mc_cycles_i > CNT_ONE) begin
            state_d = CTRL_MC_WAIT;
            cnt_d   = ex_mc_cycles_i - CNT_ONE;
          end
        end else if (lu_c) begin
          ctrl_c.pc_hold     = HOLD_ENABLE;
          ctrl_c.if_id_hold  = HOLD_ENABLE;
          ctrl_c.id_ex_flush = FLUSH_ENABLE;
        end
      end
      CTRL_MC_WAIT: begin
        ctrl_c.pc_hold    = HOLD_ENABLE;
        ctrl_c.if_id_hold = HOLD_ENABLE;
        ctrl_c.id_ex_hold = HOLD_ENABLE;
        if (cnt_q <= CNT_ONE) begin
          state_d = CTRL_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CTRL_FLUSH: begin
        ctrl_c.if_id_flush = FLUSH_ENABLE;
        ctrl_c.id_ex_flush = FLUSH_ENABLE;
        if (bus_hold_i) begin
          ctrl_c.pc_hold = HOLD_ENABLE;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = CTRL_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = CTRL_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Controls are forced inactive while reset is asserted, whatever the inputs
  always_comb begin
    ctrl_gated_c   = arst_n ? ctrl_c : '0;
    pc_hold_o      = ctrl_gated_c.pc_hold;
    if_id_hold_o   = ctrl_gated_c.if_id_hold;
    if_id_flush_o  = ctrl_gated_c.if_id_flush;
    id_ex_hold_o   = ctrl_gated_c.id_ex_hold;
    id_ex_flush_o  = ctrl_gated_c.id_ex_flush;
    pc_jump_ena_o  = ctrl_gated_c.pc_jump_ena;
    pc_jump_addr_o = arst_n ? jump_addr_c : '0;
    state_o        = state_q;
    stall_cnt_o    = stall_cnt_q;
    flush_cnt_o    = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random traffic.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned JFC   = 2;

  typedef struct packed {
    logic        rst_n;
    logic [4:0]  rs1;
    logic        rs1_ena;
    logic [4:0]  rs2;
    logic        rs2_ena;
    logic        mem_r;
    logic [4:0]  waddr;
    logic        jump;
    logic [31:0] jaddr;
    logic        mc_start;
    logic [5:0]  mc_cyc;
    logic        bus;
  } stim_t;

  typedef struct packed {
    logic        pc_hold;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        jump;
    logic [31:0] jaddr;
    logic [1:0]  state;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic        clk_100MHz = 1'b0;
  logic        arst_n = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0;
  logic        id_rs1_r_ena_i = 1'b0;
  logic [4:0]  id_rs2_addr_i = '0;
  logic        id_rs2_r_ena_i = 1'b0;
  logic        ex_mem_r_ena_i = 1'b0;
  logic [4:0]  ex_reg_w_addr_i = '0;
  logic        ex_jump_ena_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        ex_mc_start_i = 1'b0;
  logic [5:0]  ex_mc_cycles_i = '0;
  logic        bus_hold_i = 1'b0;
  logic        pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o, pc_jump_ena_o;
  logic [31:0] pc_jump_addr_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: remaining cycles of the current multi-cycle stall / jump flush
  int          mc_left = 0;
  int          fl_left = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  pipe_ctrl #(.CNT_W(CNT_W), .JUMP_FLUSH_CYCLES(JFC)) dut (
    .clk_100MHz      (clk_100MHz),
    .arst_n          (arst_n),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs1_r_ena_i  (id_rs1_r_ena_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs2_r_ena_i  (id_rs2_r_ena_i),
    .ex_mem_r_ena_i  (ex_mem_r_ena_i),
    .ex_reg_w_addr_i (ex_reg_w_addr_i),
    .ex_jump_ena_i   (ex_jump_ena_i),
    .ex_jump_addr_i  (ex_jump_addr_i),
    .ex_mc_start_i   (ex_mc_start_i),
    .ex_mc_cycles_i  (ex_mc_cycles_i),
    .bus_hold_i      (bus_hold_i),
    .pc_hold_o       (pc_hold_o),
    .if_id_hold_o    (if_id_hold_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_hold_o    (id_ex_hold_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .pc_jump_ena_o   (pc_jump_ena_o),
    .pc_jump_addr_o  (pc_jump_addr_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // Expected outputs for one cycle, from the behavioural rules
  function automatic exp_t model(input stim_t s);
    exp_t e = '0;
    logic lu;
    if (!s.rst_n) begin
      mc_left = 0;
      fl_left = 0;
      m_stall = '0;
      m_flush = '0;
      return e;
    end
    e.stall = m_stall;
    e.flush = m_flush;
    lu = s.mem_r && (s.waddr != 5'd0) &&
         ((s.rs1_ena && s.rs1 == s.waddr) || (s.rs2_ena && s.rs2 == s.waddr));
    if (mc_left > 0) begin
      e.state = 2'd1;
      {e.pc_hold, e.if_id_hold, e.id_ex_hold} = 3'b111;
      mc_left--;
    end else if (fl_left > 0) begin
      e.state = 2'd2;
      e.if_id_flush = 1'b1;
      e.id_ex_flush = 1'b1;
      e.pc_hold = s.bus;
      if (!s.bus) fl_left--;
    end else if (s.jump) begin
      e.jump = 1'b1;
      e.jaddr = s.jaddr;
      e.if_id_flush = 1'b1;
      e.id_ex_flush = 1'b1;
      fl_left = int'(JFC) - 1;
    end else if (s.bus) begin
      {e.pc_hold, e.if_id_hold, e.id_ex_hold} = 3'b111;
    end else if (s.mc_start && s.mc_cyc != 6'd0) begin
      {e.pc_hold, e.if_id_hold, e.id_ex_hold} = 3'b111;
      mc_left = int'(s.mc_cyc) - 1;
    end else if (lu) begin
      e.pc_hold = 1'b1;
      e.if_id_hold = 1'b1;
      e.id_ex_flush = 1'b1;
    end
    if (e.pc_hold) m_stall = m_stall + 32'd1;
    if (e.jump) m_flush = m_flush + 32'd1;
    return e;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue its expected response
  task automatic step(input stim_t s);
    @(posedge clk_100MHz);
    #1;
    arst_n          = s.rst_n;
    id_rs1_addr_i   = s.rs1;
    id_rs1_r_ena_i  = s.rs1_ena;
    id_rs2_addr_i   = s.rs2;
    id_rs2_r_ena_i  = s.rs2_ena;
    ex_mem_r_ena_i  = s.mem_r;
    ex_reg_w_addr_i = s.waddr;
    ex_jump_ena_i   = s.jump;
    ex_jump_addr_i  = s.jaddr;
    ex_mc_start_i   = s.mc_start;
    ex_mc_cycles_i  = s.mc_cyc;
    bus_hold_i      = s.bus;
    exp_q.push_back(model(s));
  endtask

  // Monitor: compare the presented controls mid-cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100MHz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_hold",     32'(pc_hold_o),     32'(e.pc_hold));
        chk("if_id_hold",  32'(if_id_hold_o),  32'(e.if_id_hold));
        chk("if_id_flush", 32'(if_id_flush_o), 32'(e.if_id_flush));
        chk("id_ex_hold",  32'(id_ex_hold_o),  32'(e.id_ex_hold));
        chk("id_ex_flush", 32'(id_ex_flush_o), 32'(e.id_ex_flush));
        chk("jump_ena",    32'(pc_jump_ena_o), 32'(e.jump));
        chk("jump_addr",   pc_jump_addr_o,     e.jaddr);
        chk("state",       32'(state_o),       32'(e.state));
        chk("stall_cnt",   stall_cnt_o,        e.stall);
        chk("flush_cnt",   flush_cnt_o,        e.flush);
        chk("excl_if_id",  32'(if_id_hold_o & if_id_flush_o), 32'd0);
        chk("excl_id_ex",  32'(id_ex_hold_o & id_ex_flush_o), 32'd0);
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cyc;

    // Reset with every input high
    s = '1;
    s.rst_n = 1'b0;
    repeat (3) step(s);
    repeat (2) step(idle());

    // Load-use on rs2, then the same with x0 as destination
    s = idle(); s.mem_r = 1'b1; s.waddr = 5'd5; s.rs2 = 5'd5; s.rs2_ena = 1'b1;
    step(s);
    step(idle());
    s.waddr = 5'd0; s.rs2 = 5'd0;
    step(s);
    step(idle());

    // Jump with two-cycle flush
    s = idle(); s.jump = 1'b1; s.jaddr = 32'h0000_0100;
    step(s);
    repeat (3) step(idle());

    // Four-cycle EX stall with a jump attempt in its second cycle
    s = idle(); s.mc_start = 1'b1; s.mc_cyc = 6'd4;
    step(s);
    s = idle(); s.jump = 1'b1; s.jaddr = 32'hdead_beef;
    step(s);
    repeat (4) step(idle());

    // Jump, bus hold and load-use together; then bus hold through FLUSH
    s = idle(); s.jump = 1'b1; s.jaddr = 32'h0000_2000; s.bus = 1'b1;
    s.mem_r = 1'b1; s.waddr = 5'd3; s.rs1 = 5'd3; s.rs1_ena = 1'b1;
    step(s);
    s = idle(); s.bus = 1'b1;
    repeat (3) step(s);
    repeat (3) step(idle());

    // Reset while stalled with ten cycles left
    s = idle(); s.mc_start = 1'b1; s.mc_cyc = 6'd11;
    step(s);
    s = idle(); s.rst_n = 1'b0; s.bus = 1'b1;
    step(s);
    repeat (3) step(idle());

    // Random traffic with narrow register addresses to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      s.rst_n    = ($urandom_range(0, 299) != 0);
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs1_ena  = 1'($urandom_range(0, 1));
      s.rs2      = 5'($urandom_range(0, 7));
      s.rs2_ena  = 1'($urandom_range(0, 1));
      s.mem_r    = ($urandom_range(0, 2) == 0);
      s.waddr    = 5'($urandom_range(0, 7));
      s.jump     = ($urandom_range(0, 9) == 0);
      s.jaddr    = $urandom;
      s.mc_start = ($urandom_range(0, 9) == 0);
      s.mc_cyc   = 6'($urandom_range(0, 12));
      s.bus      = ($urandom_range(0, 5) == 0);
      step(s);
    end
    repeat (2) step(idle());

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk_100MHz);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
